tile_mover: RTL and testbench
=============================

# tile_mover

Parametrised player/NPC motion controller for the maze stages. It advances a sprite one pixel per movement tick in a requested direction. Before each step it checks the sprite's two leading-edge corner tiles against an external wall-map ROM through a registered read port, and commits the step only if both tiles are clear. It also tracks facing and walk-animation frame. Instances serve the player (keyboard-driven) and the boss (chaser-driven) in the game-play top level.

## Interface
- MAP_W, 40, map width in tiles
- MAP_H, 40, map height in tiles
- TILE_LOG2, 3, tile edge = 2**TILE_LOG2 pixels
- SPR, 10, sprite edge in pixels (SPR >= 2)
- ORG_X, 60, screen x of map column 0 left edge
- ORG_Y, 30, screen y of map row 0 top edge
- CW, 9, coordinate width
- STEP_DIV, 4194304, clk cycles per movement tick (>= 4)
- RESET_X, 65, reset/default x
- RESET_Y, 125, reset/default y
- clk  in  1  clock
- rst  in  1  reset rst, asynchronous, active-high
- enable  in  1  movement allowed (stage active)
- load  in  1  synchronous load of spawn position
- spawn_x, spawn_y  in  CW  position loaded on load
- dir_valid  in  1  movement requested (level, sampled at tick)
- dir  in  2  0 up, 1 left, 2 down, 3 right
- map_addr  out  AW=$clog2(MAP_W*MAP_H)  wall-map read address, row*MAP_W+col
- map_bit  in  1  wall bit for map_addr, valid one cycle after the address is presented
- pos_x, pos_y  out  CW  sprite top-left, screen pixels
- facing  out  2  last requested direction
- anim_frame  out  2  0 idle, 1/2 walk frames
- blocked  out  1  one-cycle pulse: step rejected
- busy  out  1  collision check in progress

## Operation
- Tick counter counts 0..STEP_DIV-1 and wraps. Tick is asserted when the counter = STEP_DIV-1. The counter free-runs and is cleared only by rst.
- FSM states: IDLE, RD_A, RD_B, DECIDE.
- IDLE → RD_A: on tick && enable && dir_valid.
  - Latch dir into facing.
  - Compute candidate: up y-1, down y+1, left x-1, right x+1.
  - Drive map_addr with corner A.
- Corner pairs, using candidate coordinates:
  - up: (x, y) and (x+SPR-1, y)
  - down: (x, y+SPR-1) and (x+SPR-1, y+SPR-1)
  - left: (x, y) and (x, y+SPR-1)
  - right: (x+SPR-1, y) and (x+SPR-1, y+SPR-1)
- Tile index: col = (px-ORG_X)>>TILE_LOG2, row = (py-ORG_Y)>>TILE_LOG2. Subtraction is done in CW+1 bits.
- A corner is an out-of-map wall, with no ROM value used, if any of these hold: px < ORG_X, py < ORG_Y, col >= MAP_W, row >= MAP_H.
- RD_A → RD_B: register wall_A from map_bit (or out-of-map), then drive corner B.
- RD_B → DECIDE: register wall_B.
- DECIDE → IDLE:
  - If !wall_A && !wall_B: pos ← candidate.
  - Else: pos unchanged and blocked pulses for 1 cycle.
- Tick with !dir_valid or !enable: no check, anim_frame ← 0, facing kept.
- Tick arriving while busy is ignored. STEP_DIV >= 4 makes this impossible in legal configurations.
- load: highest priority, any state.
  - pos ← spawn.
  - FSM → IDLE, aborting any check with no commit and no blocked pulse.
  - anim_frame ← 0. facing unchanged.
- enable dropping mid-check does not abort; the check completes.

## Timing
- Reset values: pos_x=RESET_X, pos_y=RESET_Y, facing=3, anim_frame=0, blocked=0, busy=0, map_addr=0, FSM IDLE, tick counter 0.
- Latency: tick edge → pos update 3 clk (IDLE→RD_A→RD_B→DECIDE; pos registered on the DECIDE→IDLE edge).
- busy is high in RD_A, RD_B, DECIDE.
- facing is updated on the IDLE→RD_A edge.
- map_addr holds its last value while IDLE.
- rst mid-check: immediate return to reset values.

## Configuration
- TILE_MOVER_ANIM_EN defined:
  - anim_frame becomes 1 on the first committed step after idle, then toggles 1↔2 on each committed step.
  - A blocked step leaves it unchanged.
- TILE_MOVER_ANIM_EN undefined: anim_frame is constant 0 and the animation logic is absent.

## Test plan
- Open floor, defaults, STEP_DIV=4, dir=3 held 8 ticks from (65,125) → pos_x=73, pos_y=125, blocked never, anim (EN) 1,2,1,2,...
- Wall at tile col 2 row 12, pos (66,126), dir=3 → corner x=76 gives col 2; blocked pulses every tick; pos_x stays 66; facing=3.
- Map edge: pos (60,40), dir=1 → candidate x=59 < ORG_X → blocked, no commit, map_bit ignored.
- Latency: tick at cycle T, clear tiles → busy high T+1..T+3; pos changes visible at T+4; map_addr shows A then B on consecutive cycles.
- load asserted during RD_B with spawn (100,100) → pos=(100,100) next cycle; FSM IDLE; no blocked pulse; anim_frame=0.
- dir_valid low at a tick after walking → anim_frame=0, pos and facing unchanged; rst mid-check → all outputs at reset values.

Source files
------------

// File: rtl/tile_mover.sv
// tile_mover: one-pixel-per-tick sprite motion with wall-map collision check.
// Each tick with a request probes the two leading-edge corner tiles of the
// candidate position through a registered wall-map ROM port and commits the
// step only if both tiles are clear.
// Optional build macro: TILE_MOVER_ANIM_EN enables the walk-animation frame
// counter; without it anim_frame is tied to 0.
//
// state  | meaning
// IDLE   | waiting for a movement tick; map_addr holds its last value
// RD_A   | corner A address on map_addr, ROM read in flight
// RD_B   | corner B address on map_addr, corner A bit arriving on map_bit
// DECIDE | corner B bit on map_bit; commit step or pulse blocked
module tile_mover #(
    parameter int MAP_W     = 40,
    parameter int MAP_H     = 40,
    parameter int TILE_LOG2 = 3,
    parameter int SPR       = 10,
    parameter int ORG_X     = 60,
    parameter int ORG_Y     = 30,
    parameter int CW        = 9,
    parameter int STEP_DIV  = 4194304,
    parameter int RESET_X   = 65,
    parameter int RESET_Y   = 125,
    localparam int AW       = $clog2(MAP_W * MAP_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          load,
    input  logic [CW-1:0] spawn_x,
    input  logic [CW-1:0] spawn_y,
    input  logic          dir_valid,
    input  logic [1:0]    dir,
    output logic [AW-1:0] map_addr,
    input  logic          map_bit,
    output logic [CW-1:0] pos_x,
    output logic [CW-1:0] pos_y,
    output logic [1:0]    facing,
    output logic [1:0]    anim_frame,
    output logic          blocked,
    output logic          busy
);

    localparam int TW = $clog2(STEP_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(STEP_DIV - 1);

    localparam logic [CW:0] ORG_X_E = (CW+1)'(ORG_X);
    localparam logic [CW:0] ORG_Y_E = (CW+1)'(ORG_Y);
    localparam logic [CW:0] MAP_W_E = (CW+1)'(MAP_W);
    localparam logic [CW:0] MAP_H_E = (CW+1)'(MAP_H);
    localparam logic [CW:0] SPR_M1  = (CW+1)'(SPR - 1);

    typedef enum logic [1:0] {IDLE, RD_A, RD_B, DECIDE} state_t;

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [CW-1:0] cand_x, cand_y;
    logic [CW-1:0] nx, ny;
    logic [AW:0]   probe_a, probe_b;
    logic          oob_a, oob_b;
    logic          wall_a;
    logic          wall_b;

    // Corner probe: returns {out_of_map, tile address}. Corner coordinates are
    // widened by one bit so x+SPR-1 cannot wrap and px<ORG shows up cleanly.
    function automatic logic [AW:0] probe(input logic [CW-1:0] x,
                                          input logic [CW-1:0] y,
                                          input logic [1:0]    d,
                                          input logic          second);
        logic          off_x, off_y;
        logic [CW:0]   px, py, dx, dy, col, row;
        logic          oob;
        case (d)
            2'd0:    begin off_x = second; off_y = 1'b0;   end
            2'd1:    begin off_x = 1'b0;   off_y = second; end
            2'd2:    begin off_x = second; off_y = 1'b1;   end
            default: begin off_x = 1'b1;   off_y = second; end
        endcase
        px  = {1'b0, x} + (off_x ? SPR_M1 : '0);
        py  = {1'b0, y} + (off_y ? SPR_M1 : '0);
        dx  = px - ORG_X_E;
        dy  = py - ORG_Y_E;
        col = dx >> TILE_LOG2;
        row = dy >> TILE_LOG2;
        oob = (px < ORG_X_E) || (py < ORG_Y_E) || (col >= MAP_W_E) || (row >= MAP_H_E);
        return {oob, AW'(row) * AW'(MAP_W) + AW'(col)};
    endfunction

    assign tick = (tick_cnt == TICK_LAST);

    // Corner B's ROM bit arrives during DECIDE, so it is used straight from
    // the port rather than registered again.
    assign wall_b = oob_b | map_bit;

    // Candidate position from the live request and the two corner probes.
    always_comb begin
        nx = pos_x;
        ny = pos_y;
        case (dir)
            2'd0:    ny = pos_y - CW'(1);
            2'd1:    nx = pos_x - CW'(1);
            2'd2:    ny = pos_y + CW'(1);
            default: nx = pos_x + CW'(1);
        endcase
        probe_a = probe(nx, ny, dir, 1'b0);
        probe_b = probe(cand_x, cand_y, facing, 1'b1);
    end

    // Free-running movement tick divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TW'(1);
    end

`ifdef TILE_MOVER_ANIM_EN
    logic [1:0] anim_q;
    assign anim_frame = anim_q;
`else
    assign anim_frame = 2'd0;
`endif

    // Collision-check sequencer and position/facing registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pos_x    <= CW'(RESET_X);
            pos_y    <= CW'(RESET_Y);
            facing   <= 2'd3;
            blocked  <= 1'b0;
            busy     <= 1'b0;
            map_addr <= '0;
            cand_x   <= '0;
            cand_y   <= '0;
            oob_a    <= 1'b0;
            oob_b    <= 1'b0;
            wall_a   <= 1'b0;
`ifdef TILE_MOVER_ANIM_EN
            anim_q   <= 2'd0;
`endif
        end else begin
            blocked <= 1'b0;
            if (load) begin
                pos_x <= spawn_x;
                pos_y <= spawn_y;
                state <= IDLE;
                busy  <= 1'b0;
`ifdef TILE_MOVER_ANIM_EN
                anim_q <= 2'd0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (tick) begin
                            if (enable && dir_valid) begin
                                facing   <= dir;
                                cand_x   <= nx;
                                cand_y   <= ny;
                                map_addr <= probe_a[AW-1:0];
                                oob_a    <= probe_a[AW];
                                busy     <= 1'b1;
                                state    <= RD_A;
                            end else begin
`ifdef TILE_MOVER_ANIM_EN
                                anim_q <= 2'd0;
`endif
                            end
                        end
                    end
                    RD_A: begin
                        map_addr <= probe_b[AW-1:0];
                        oob_b    <= probe_b[AW];
                        state    <= RD_B;
                    end
                    RD_B: begin
                        wall_a <= oob_a | map_bit;
                        state  <= DECIDE;
                    end
                    default: begin
                        if (!wall_a && !wall_b) begin
                            pos_x <= cand_x;
                            pos_y <= cand_y;
`ifdef TILE_MOVER_ANIM_EN
                            anim_q <= (anim_q == 2'd1) ? 2'd2 : 2'd1;
`endif
                        end else begin
                            blocked <= 1'b1;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tile_mover.sv
// Bench for tile_mover with STEP_DIV=4 and a small wall-map ROM
// (one wall tile at column 2, row 12).
module tb_tile_mover;

    localparam int AW = 11;
`ifdef TILE_MOVER_ANIM_EN
    localparam bit ANIM = 1'b1;
`else
    localparam bit ANIM = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b1;
    logic          load = 1'b0;
    logic [8:0]    spawn_x = '0;
    logic [8:0]    spawn_y = '0;
    logic          dir_valid = 1'b0;
    logic [1:0]    dir = 2'd3;
    logic [AW-1:0] map_addr;
    logic          map_bit = 1'b0;
    logic [8:0]    pos_x, pos_y;
    logic [1:0]    facing, anim_frame;
    logic          blocked, busy;

    int n_pass = 0;
    int n_total = 0;

    logic wall_mem [0:1599];
    int   tb_cnt;

    tile_mover #(.STEP_DIV(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load),
        .spawn_x(spawn_x), .spawn_y(spawn_y),
        .dir_valid(dir_valid), .dir(dir),
        .map_addr(map_addr), .map_bit(map_bit),
        .pos_x(pos_x), .pos_y(pos_y), .facing(facing),
        .anim_frame(anim_frame), .blocked(blocked), .busy(busy)
    );

    always #5 clk = ~clk;

    // Registered-read wall ROM; addresses past the map read as wall.
    always @(posedge clk)
        map_bit <= (map_addr < 11'd1600) ? wall_mem[map_addr] : 1'b1;

    // Reference tick counter: tick is the cycle where tb_cnt == 3.
    always @(posedge clk or posedge rst)
        if (rst) tb_cnt <= 0;
        else     tb_cnt <= (tb_cnt == 3) ? 0 : tb_cnt + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic wait_tick();
        int n = 0;
        while (tb_cnt != 3 && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (tb_cnt != 3) begin
            n_total++;
            $display("FAIL tick_wait: no tick within %0d cycles", n);
        end
    endtask

    typedef struct {
        int sx, sy, dv, en, d;
        int ex, ey, ef, eb;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int nblk;

        vecs[0]  = '{65, 125, 1, 1, 3,  66, 125, 3, 0};
        vecs[1]  = '{66, 126, 1, 1, 3,  66, 126, 3, 1};
        vecs[2]  = '{60,  40, 1, 1, 1,  60,  40, 1, 1};
        vecs[3]  = '{100,100, 1, 1, 0, 100,  99, 0, 0};
        vecs[4]  = '{100,100, 1, 1, 2, 100, 101, 2, 0};
        vecs[5]  = '{80,  30, 1, 1, 0,  80,  30, 0, 1};
        vecs[6]  = '{369, 50, 1, 1, 3, 370,  50, 3, 0};
        vecs[7]  = '{370, 50, 1, 1, 3, 370,  50, 3, 1};
        vecs[8]  = '{100,340, 1, 1, 2, 100, 340, 2, 1};
        vecs[9]  = '{100,100, 0, 1, 1, 100, 100, 2, 0};
        vecs[10] = '{100,100, 1, 0, 3, 100, 100, 2, 0};
        vecs[11] = '{70, 134, 1, 1, 0,  70, 134, 0, 1};
        vecs[12] = '{84, 120, 1, 1, 1,  84, 120, 1, 1};

        for (int i = 0; i < 1600; i++) wall_mem[i] = 1'b0;
        wall_mem[482] = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_pos_x", int'(pos_x), 65);
        chk("rst_pos_y", int'(pos_y), 125);
        chk("rst_facing", int'(facing), 3);
        chk("rst_anim", int'(anim_frame), 0);
        chk("rst_blocked", int'(blocked), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_map_addr", int'(map_addr), 0);
        rst = 1'b0;

        // Latency and address sequence from reset position, moving right
        @(negedge clk);
        dir = 2'd3; dir_valid = 1'b1;
        wait_tick();
        @(negedge clk);
        chk("lat_busy_t1", int'(busy), 1);
        chk("lat_addr_a", int'(map_addr), 441);
        @(negedge clk);
        chk("lat_busy_t2", int'(busy), 1);
        chk("lat_addr_b", int'(map_addr), 521);
        @(negedge clk);
        chk("lat_busy_t3", int'(busy), 1);
        chk("lat_pos_t3", int'(pos_x), 65);
        @(negedge clk);
        chk("lat_busy_t4", int'(busy), 0);
        chk("lat_pos_t4", int'(pos_x), 66);
        dir_valid = 1'b0;

        // Table-driven single steps
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            dir_valid = 1'b0;
            load = 1'b1;
            spawn_x = 9'(vecs[i].sx);
            spawn_y = 9'(vecs[i].sy);
            @(negedge clk);
            load = 1'b0;
            enable = vecs[i].en[0];
            dir_valid = vecs[i].dv[0];
            dir = 2'(vecs[i].d);
            wait_tick();
            nblk = 0;
            repeat (4) begin
                @(negedge clk);
                if (blocked) nblk++;
            end
            dir_valid = 1'b0;
            enable = 1'b1;
            chk($sformatf("vec%0d_pos_x", i), int'(pos_x), vecs[i].ex);
            chk($sformatf("vec%0d_pos_y", i), int'(pos_y), vecs[i].ey);
            chk($sformatf("vec%0d_facing", i), int'(facing), vecs[i].ef);
            chk($sformatf("vec%0d_blocked", i), nblk, vecs[i].eb);
        end

        // Open-floor walk: 8 ticks right from (65,125)
        @(negedge clk);
        load = 1'b1; spawn_x = 9'd65; spawn_y = 9'd125;
        @(negedge clk);
        load = 1'b0; dir = 2'd3; dir_valid = 1'b1;
        wait_tick();
        nblk = 0;
        for (int k = 0; k < 8; k++) begin
            repeat (4) begin
                @(negedge clk);
                if (blocked) nblk++;
            end
            chk($sformatf("walk%0d_pos_x", k), int'(pos_x), 66 + k);
            chk($sformatf("walk%0d_anim", k), int'(anim_frame), ANIM ? ((k % 2 == 0) ? 1 : 2) : 0);
        end
        chk("walk_pos_y", int'(pos_y), 125);
        chk("walk_blocked", nblk, 0);

        // Load during RD_B aborts the check in flight
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_rdb", int'(busy), 1);
        load = 1'b1; spawn_x = 9'd100; spawn_y = 9'd100; dir_valid = 1'b0;
        @(negedge clk);
        load = 1'b0;
        chk("abort_pos_x", int'(pos_x), 100);
        chk("abort_pos_y", int'(pos_y), 100);
        chk("abort_busy", int'(busy), 0);
        chk("abort_anim", int'(anim_frame), 0);
        nblk = 0;
        repeat (5) begin
            @(negedge clk);
            if (blocked) nblk++;
        end
        chk("abort_blocked", nblk, 0);
        chk("abort_pos_hold", int'(pos_x), 100);

        // One step, then a tick with dir_valid low
        dir = 2'd3; dir_valid = 1'b1;
        wait_tick();
        repeat (4) @(negedge clk);
        chk("idle_step_pos", int'(pos_x), 101);
        chk("idle_step_anim", int'(anim_frame), ANIM ? 1 : 0);
        dir_valid = 1'b0; dir = 2'd0;
        @(negedge clk);
        chk("idle_anim", int'(anim_frame), 0);
        chk("idle_pos_x", int'(pos_x), 101);
        chk("idle_pos_y", int'(pos_y), 100);
        chk("idle_facing", int'(facing), 3);
        chk("idle_busy", int'(busy), 0);

        // Reset mid-check
        dir = 2'd1; dir_valid = 1'b1;
        wait_tick();
        @(negedge clk);
        chk("mid_busy", int'(busy), 1);
        chk("mid_facing", int'(facing), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_pos_x", int'(pos_x), 65);
        chk("mid_rst_pos_y", int'(pos_y), 125);
        chk("mid_rst_facing", int'(facing), 3);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_blocked", int'(blocked), 0);
        chk("mid_rst_map_addr", int'(map_addr), 0);
        chk("mid_rst_anim", int'(anim_frame), 0);
        @(negedge clk);
        dir_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
